dispatch_queue: RTL

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between decode and the reservation stations.
// Snoops the CDB so queued sources wake up before they reach the head.
module dispatch_queue #(
    parameter int XLEN        = 32,
    parameter int NUM_RS      = 4,
    parameter int DQ_DEPTH    = 4,
    parameter int ROB_TAG_LEN = 3,
    parameter int FUNC_W      = 4,
    parameter int FU_W        = $clog2(NUM_RS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FU_W-1:0]             in_fu,
    input  logic [FUNC_W-1:0]           in_func,
    input  logic [XLEN-1:0]             in_imm,
    input  logic [XLEN-1:0]             in_pc,
    input  logic [4:0]                  in_dest_reg,
    input  logic                        in_src1_ready,
    input  logic [ROB_TAG_LEN-1:0]      in_src1_tag,
    input  logic [XLEN-1:0]             in_src1_value,
    input  logic                        in_src2_ready,
    input  logic [ROB_TAG_LEN-1:0]      in_src2_tag,
    input  logic [XLEN-1:0]             in_src2_value,
    input  logic                        cdb_valid,
    input  logic [ROB_TAG_LEN-1:0]      cdb_tag,
    input  logic [XLEN-1:0]             cdb_value,
    input  logic                        flush,
    input  logic                        rob_alloc_ready,
    input  logic [ROB_TAG_LEN-1:0]      rob_alloc_tag,
    output logic                        rob_alloc,
    output logic [4:0]                  rob_dest_reg,
    input  logic [NUM_RS-1:0]           rs_full,
    output logic [NUM_RS-1:0]           rs_load,
    output logic [FUNC_W-1:0]           out_func,
    output logic [XLEN-1:0]             out_imm,
    output logic [XLEN-1:0]             out_pc,
    output logic [ROB_TAG_LEN-1:0]      out_tag_dest,
    output logic                        out_src1_ready,
    output logic [ROB_TAG_LEN-1:0]      out_src1_tag,
    output logic [XLEN-1:0]             out_src1_value,
    output logic                        out_src2_ready,
    output logic [ROB_TAG_LEN-1:0]      out_src2_tag,
    output logic [XLEN-1:0]             out_src2_value,
    output logic [$clog2(DQ_DEPTH):0]   count,
    output logic                        err_fu
);

    localparam int PTR_W = $clog2(DQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FU_W-1:0]        q_fu     [DQ_DEPTH];
    logic [FUNC_W-1:0]      q_func   [DQ_DEPTH];
    logic [XLEN-1:0]        q_imm    [DQ_DEPTH];
    logic [XLEN-1:0]        q_pc     [DQ_DEPTH];
    logic [4:0]             q_dest   [DQ_DEPTH];
    logic                   q_s1_rdy [DQ_DEPTH];
    logic [ROB_TAG_LEN-1:0] q_s1_tag [DQ_DEPTH];
    logic [XLEN-1:0]        q_s1_val [DQ_DEPTH];
    logic                   q_s2_rdy [DQ_DEPTH];
    logic [ROB_TAG_LEN-1:0] q_s2_tag [DQ_DEPTH];
    logic [XLEN-1:0]        q_s2_val [DQ_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic              accept;
    logic              fu_legal;
    logic              push;
    logic              fire;
    logic [NUM_RS-1:0] head_sel;
    logic              in_s1_hit;
    logic              in_s2_hit;
    logic              hd_s1_hit;
    logic              hd_s2_hit;

    assign in_ready = (count != CNT_W'(DQ_DEPTH)) && !flush;
    assign accept   = in_valid && in_ready;
    assign fu_legal = 32'(in_fu) < NUM_RS;
    assign push     = accept && fu_legal;

    // Only legal FU codes are ever stored, so the shift never overflows.
    assign head_sel = NUM_RS'(1) << q_fu[head];
    assign fire     = (count != '0) && !(|(rs_full & head_sel))
                      && rob_alloc_ready && !flush;

    assign rs_load      = fire ? head_sel : '0;
    assign rob_alloc    = fire;
    assign out_tag_dest = rob_alloc_tag;
    assign rob_dest_reg = q_dest[head];
    assign out_func     = q_func[head];
    assign out_imm      = q_imm[head];
    assign out_pc       = q_pc[head];

    assign in_s1_hit = !in_src1_ready && cdb_valid && (cdb_tag == in_src1_tag);
    assign in_s2_hit = !in_src2_ready && cdb_valid && (cdb_tag == in_src2_tag);

    // Same-cycle CDB bypass so a head woken this cycle need not wait.
    assign hd_s1_hit = !q_s1_rdy[head] && cdb_valid
                       && (cdb_tag == q_s1_tag[head]);
    assign hd_s2_hit = !q_s2_rdy[head] && cdb_valid
                       && (cdb_tag == q_s2_tag[head]);

    assign out_src1_ready = q_s1_rdy[head] || hd_s1_hit;
    assign out_src1_tag   = q_s1_tag[head];
    assign out_src1_value = hd_s1_hit ? cdb_value : q_s1_val[head];
    assign out_src2_ready = q_s2_rdy[head] || hd_s2_hit;
    assign out_src2_tag   = q_s2_tag[head];
    assign out_src2_value = hd_s2_hit ? cdb_value : q_s2_val[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            err_fu <= 1'b0;
        end else begin
            if (accept && !fu_legal)
                err_fu <= 1'b1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= tail + PTR_W'(1);
                if (fire)
                    head <= head + PTR_W'(1);
                if (push && !fire)
                    count <= count + CNT_W'(1);
                else if (!push && fire)
                    count <= count - CNT_W'(1);
            end
        end
    end

    // Payload needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DQ_DEPTH; i++) begin
            if (!q_s1_rdy[i] && cdb_valid && (cdb_tag == q_s1_tag[i])) begin
                q_s1_rdy[i] <= 1'b1;
                q_s1_val[i] <= cdb_value;
            end
            if (!q_s2_rdy[i] && cdb_valid && (cdb_tag == q_s2_tag[i])) begin
                q_s2_rdy[i] <= 1'b1;
                q_s2_val[i] <= cdb_value;
            end
        end
        if (push) begin
            q_fu[tail]     <= in_fu;
            q_func[tail]   <= in_func;
            q_imm[tail]    <= in_imm;
            q_pc[tail]     <= in_pc;
            q_dest[tail]   <= in_dest_reg;
            q_s1_rdy[tail] <= in_src1_ready || in_s1_hit;
            q_s1_tag[tail] <= in_src1_tag;
            q_s1_val[tail] <= in_s1_hit ? cdb_value : in_src1_value;
            q_s2_rdy[tail] <= in_src2_ready || in_s2_hit;
            q_s2_tag[tail] <= in_src2_tag;
            q_s2_val[tail] <= in_s2_hit ? cdb_value : in_src2_value;
        end
    end

endmodule
